picosoc_memarb: RTL and testbench

PICOSOC_MEMARB -- requirements
Module: picosoc_memarb

---
 rtl/picosoc_memarb.sv | 193 +++++++++++++++++++
 tb/tb_picosoc_memarb.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/picosoc_memarb.sv
// picosoc_memarb -- two-master round-robin arbiter for a picorv32-style
// valid/ready memory bus. Master 0 is the CPU, master 1 the DMA/debug port.
// After a grant the slave bus is a zero-latency combinational pass-through
// of the owning master, driven from the owner register.
//
// Optional build macro: PICOSOC_MEMARB_TIMEOUT_EN
//   Adds an 8-bit slave-response timeout counter and the sticky err output.
//   When the timeout expires, the owner receives ERR_RDATA with a ready pulse.
module picosoc_memarb #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_valid,
    input  logic        m0_instr,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    input  logic        m1_instr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,
    output logic        s_valid,
    output logic        s_instr,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic        s_ready,
    input  logic [31:0] s_rdata
`ifdef PICOSOC_MEMARB_TIMEOUT_EN
    ,
    output logic        err
`endif
);

    // The timeout limit must fit the 8-bit counter and be non-zero.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("picosoc_memarb: TIMEOUT_CYCLES must be in 1..255");
    end

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t state_r;
    state_t state_s;
    logic   owner_r;
    logic   owner_s;
    logic   last_r;
    logic   last_s;

    logic        owner_valid_s;
    logic        timeout_s;
    logic        resp_ready_s;
    logic [31:0] resp_data_s;

`ifdef PICOSOC_MEMARB_TIMEOUT_EN
    localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYCLES);

    logic [7:0] tcnt_r;
    logic [7:0] tcnt_s;
    logic       err_r;
    logic       err_s;

    // Timeout fires only when the slave has not answered in the limit cycle;
    // a coincident s_ready wins and completes normally.
    assign timeout_s = (state_r == ST_BUSY) && (tcnt_r == TO_LIMIT) && !s_ready;
    assign err       = err_r;

    // Timeout counter and sticky error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            tcnt_r <= 8'd0;
            err_r  <= 1'b0;
        end else begin
            tcnt_r <= tcnt_s;
            err_r  <= err_s;
        end
    end

    // Counter clears on grant, counts unanswered BUSY cycles; err sets on expiry.
    always_comb begin
        tcnt_s = tcnt_r;
        err_s  = err_r;
        if (state_r == ST_IDLE) begin
            tcnt_s = 8'd0;
        end else if (!s_ready && !timeout_s) begin
            tcnt_s = tcnt_r + 8'd1;
        end else if (timeout_s) begin
            err_s = 1'b1;
        end else begin
            tcnt_s = tcnt_r;
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    // Owner's request line; only the registered owner steers the mux.
    assign owner_valid_s = owner_r ? m1_valid : m0_valid;

    // Arbiter state registers; reset makes master 0 win the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            owner_r <= 1'b0;
            last_r  <= 1'b1;
        end else begin
            state_r <= state_s;
            owner_r <= owner_s;
            last_r  <= last_s;
        end
    end

    // Next-state logic: grant in IDLE, release in BUSY on response or timeout.
    always_comb begin
        state_s = state_r;
        owner_s = owner_r;
        last_s  = last_r;
        case (state_r)
            ST_IDLE: begin
                if (m0_valid && m1_valid) begin
                    owner_s = ~last_r;
                    state_s = ST_BUSY;
                end else if (m0_valid) begin
                    owner_s = 1'b0;
                    state_s = ST_BUSY;
                end else if (m1_valid) begin
                    owner_s = 1'b1;
                    state_s = ST_BUSY;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (s_ready || timeout_s) begin
                    state_s = ST_IDLE;
                    last_s  = owner_r;
                end else begin
                    state_s = ST_BUSY;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Response seen by the owner: slave data, or the error word on timeout.
    always_comb begin
        resp_ready_s = 1'b0;
        resp_data_s  = s_rdata;
        if (state_r == ST_BUSY) begin
            resp_ready_s = s_ready || timeout_s;
            resp_data_s  = timeout_s ? ERR_RDATA : s_rdata;
        end else begin
            resp_ready_s = 1'b0;
        end
    end

    // Slave-side payload mux and per-master response routing.
    always_comb begin
        s_valid  = 1'b0;
        s_instr  = owner_r ? m1_instr : m0_instr;
        s_addr   = owner_r ? m1_addr  : m0_addr;
        s_wdata  = owner_r ? m1_wdata : m0_wdata;
        s_wstrb  = owner_r ? m1_wstrb : m0_wstrb;
        m0_ready = 1'b0;
        m1_ready = 1'b0;
        m0_rdata = 32'h0;
        m1_rdata = 32'h0;
        if (state_r == ST_BUSY) begin
            s_valid = owner_valid_s && !timeout_s;
            if (owner_r) begin
                m1_ready = resp_ready_s;
                m1_rdata = resp_data_s;
            end else begin
                m0_ready = resp_ready_s;
                m0_rdata = resp_data_s;
            end
        end else begin
            s_valid = 1'b0;
        end
    end

endmodule

// File: tb/tb_picosoc_memarb.sv
// Self-checking bench for picosoc_memarb: directed scenarios plus a random
// phase, all compared each cycle against a transaction-level model.
// Build with +define+PICOSOC_MEMARB_TIMEOUT_EN to exercise the timeout path.
module tb_picosoc_memarb;

    localparam int          TO   = 4;
    localparam logic [31:0] ERRD = 32'hDEAD_BEEF;
`ifdef PICOSOC_MEMARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_valid, m0_instr, m0_ready;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic [3:0]  m0_wstrb;
    logic        m1_valid, m1_instr, m1_ready;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic [3:0]  m1_wstrb;
    logic        s_valid, s_instr, s_ready;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_wstrb;
    logic        err;

    always #5 clk = ~clk;

    picosoc_memarb #(.TIMEOUT_CYCLES(TO), .ERR_RDATA(ERRD)) dut (
        .clk(clk), .reset(reset),
        .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
        .s_valid(s_valid), .s_instr(s_instr), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_wstrb(s_wstrb), .s_ready(s_ready), .s_rdata(s_rdata)
`ifdef PICOSOC_MEMARB_TIMEOUT_EN
        , .err(err)
`endif
    );
`ifndef PICOSOC_MEMARB_TIMEOUT_EN
    assign err = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Transaction-level model: is a transfer in flight, for whom, who went last,
    // how long it has waited, and whether a timeout has ever happened.
    bit md_busy;
    int md_who;
    int md_prev;
    int md_wait;
    bit md_err;

    // Values observed in the most recent cycle (for directed bookkeeping).
    logic        o_sv, o_r0, o_r1, o_err;
    logic [31:0] o_d0, o_d1, o_saddr, o_swdata;
    logic [3:0]  o_swstrb;
    int c_sv, c_r0, c_r1, stepno;
    logic [31:0] cap0, cap1;
    int grants[$];
    int gidx[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock cycle: compare outputs to the model, then advance the model.
    task automatic step();
        bit          tmo;
        bit          v[2];
        logic [31:0] a[2], w[2];
        logic [3:0]  st[2];
        bit          ins[2];
        logic [31:0] exp_d[2];
        bit          exp_r[2];
        #1;
        v[0] = m0_valid; v[1] = m1_valid;
        a[0] = m0_addr;  a[1] = m1_addr;
        w[0] = m0_wdata; w[1] = m1_wdata;
        st[0] = m0_wstrb; st[1] = m1_wstrb;
        ins[0] = m0_instr; ins[1] = m1_instr;
        tmo = TO_EN && md_busy && (md_wait == TO) && !s_ready;
        exp_r[0] = 1'b0; exp_r[1] = 1'b0;
        exp_d[0] = 32'h0; exp_d[1] = 32'h0;
        if (md_busy) begin
            exp_r[md_who] = s_ready || tmo;
            exp_d[md_who] = tmo ? ERRD : s_rdata;
        end
        chk("s_valid", s_valid, (md_busy && !tmo) ? v[md_who] : 1'b0);
        chk("m0_ready", m0_ready, exp_r[0]);
        chk("m1_ready", m1_ready, exp_r[1]);
        chk("m0_rdata", m0_rdata, exp_d[0]);
        chk("m1_rdata", m1_rdata, exp_d[1]);
        if (TO_EN) chk("err", err, md_err);
        if (md_busy) begin
            chk("s_addr", s_addr, a[md_who]);
            chk("s_wdata", s_wdata, w[md_who]);
            chk("s_wstrb", s_wstrb, st[md_who]);
            chk("s_instr", s_instr, ins[md_who]);
        end
        o_sv = s_valid; o_r0 = m0_ready; o_r1 = m1_ready; o_err = err;
        o_d0 = m0_rdata; o_d1 = m1_rdata;
        o_saddr = s_addr; o_swdata = s_wdata; o_swstrb = s_wstrb;
        if (s_valid) c_sv++;
        if (m0_ready) begin c_r0++; cap0 = m0_rdata; grants.push_back(0); gidx.push_back(stepno); end
        if (m1_ready) begin c_r1++; cap1 = m1_rdata; grants.push_back(1); gidx.push_back(stepno); end
        stepno++;
        // Model advance, computed on the inputs just checked.
        @(posedge clk);
        if (reset) begin
            md_busy = 1'b0; md_who = 0; md_prev = 1; md_wait = 0; md_err = 1'b0;
        end else if (!md_busy) begin
            if (v[0] || v[1]) begin
                md_who  = (v[0] && v[1]) ? 1 - md_prev : (v[0] ? 0 : 1);
                md_busy = 1'b1;
                md_wait = 0;
            end
        end else if (s_ready || tmo) begin
            md_busy = 1'b0;
            md_prev = md_who;
            if (!s_ready) md_err = 1'b1;
        end else begin
            md_wait++;
        end
        #1;
    endtask

    initial begin
        int wt[2];
        int lat;
        reset = 1'b1;
        m0_valid = 1'b0; m0_instr = 1'b0; m0_addr = 32'h0; m0_wdata = 32'h0; m0_wstrb = 4'h0;
        m1_valid = 1'b0; m1_instr = 1'b0; m1_addr = 32'h0; m1_wdata = 32'h0; m1_wstrb = 4'h0;
        s_ready = 1'b0; s_rdata = 32'h0;
        md_busy = 1'b0; md_who = 0; md_prev = 1; md_wait = 0; md_err = 1'b0;
        stepno = 0;
        step(); step();
        reset = 1'b0;
        chk("reset_s_valid", o_sv, 1'b0);

        // Single CPU read, slave answers in the second BUSY cycle.
        c_sv = 0; c_r0 = 0; cap0 = 32'h0;
        m0_valid = 1'b1; m0_addr = 32'h0000_0010;
        step();
        step();
        s_ready = 1'b1; s_rdata = 32'h1234_5678;
        step();
        m0_valid = 1'b0; s_ready = 1'b0;
        step();
        chk("t1_svalid_cycles", c_sv, 2);
        chk("t1_m0_ready_pulses", c_r0, 1);
        chk("t1_m0_rdata", cap0, 32'h1234_5678);

        // Both masters request continuously, immediate slave: strict alternation.
        grants.delete(); gidx.delete(); stepno = 0;
        m0_valid = 1'b1; m0_addr = 32'h0000_0A00;
        m1_valid = 1'b1; m1_addr = 32'h0000_0B00;
        s_ready = 1'b1; s_rdata = 32'h5555_AAAA;
        for (int i = 0; i < 8; i++) step();
        m0_valid = 1'b0; m1_valid = 1'b0; s_ready = 1'b0;
        chk("t2_grant_count", grants.size(), 4);
        for (int i = 0; i < 4 && i < grants.size(); i++) begin
            chk("t2_grant_order", grants[i], (i % 2 == 0) ? 1 : 0);
            chk("t2_grant_cycle", gidx[i], 2 * i + 1);
        end

        // DMA write while CPU is idle: payload must be the DMA's throughout.
        c_r0 = 0; c_r1 = 0;
        m1_valid = 1'b1; m1_addr = 32'h0000_0100; m1_wstrb = 4'b0011; m1_wdata = 32'hCAFE_0123;
        step();
        for (int i = 0; i < 4; i++) begin
            s_ready = (i == 3);
            step();
            chk("t3_s_addr", o_saddr, 32'h0000_0100);
            chk("t3_s_wstrb", o_swstrb, 4'b0011);
            chk("t3_s_wdata", o_swdata, 32'hCAFE_0123);
        end
        m1_valid = 1'b0; s_ready = 1'b0; m1_wstrb = 4'h0;
        step();
        chk("t3_m0_ready_count", c_r0, 0);
        chk("t3_m1_ready_count", c_r1, 1);

        // Reset in the middle of a DMA transfer aborts it; next tie goes to CPU.
        c_r1 = 0;
        m1_valid = 1'b1; m1_addr = 32'h0000_0200;
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        m0_valid = 1'b1; m0_addr = 32'h0000_0300;
        step();
        chk("t4_svalid_after_reset", o_sv, 1'b0);
        step();
        chk("t4_tie_goes_to_m0", o_saddr, 32'h0000_0300);
        chk("t4_m1_never_ready", c_r1, 0);
        s_ready = 1'b1;
        step();
        m0_valid = 1'b0;
        step(); step();
        m1_valid = 1'b0; s_ready = 1'b0;
        step();

`ifdef PICOSOC_MEMARB_TIMEOUT_EN
        // Slave never answers: timeout in the fifth BUSY cycle, err sticks.
        reset = 1'b1; step(); reset = 1'b0;
        m0_valid = 1'b1; m0_addr = 32'h0000_0400;
        step();
        for (int i = 1; i <= 5; i++) begin
            step();
            chk("t5_m0_ready", o_r0, (i == 5));
            if (i == 5) begin
                chk("t5_m0_rdata", o_d0, 32'hDEAD_BEEF);
                chk("t5_s_valid", o_sv, 1'b0);
            end
        end
        m0_valid = 1'b0;
        step(); step();
        chk("t5_err_sticky", o_err, 1'b1);
        reset = 1'b1; step(); reset = 1'b0;
        step();
        chk("t5_err_cleared", o_err, 1'b0);

        // Slave answers exactly in the timeout cycle: normal completion.
        m0_valid = 1'b1;
        step();
        for (int i = 0; i < 4; i++) step();
        s_ready = 1'b1; s_rdata = 32'hA5A5_0F0F;
        step();
        chk("t6_m0_ready", o_r0, 1'b1);
        chk("t6_m0_rdata", o_d0, 32'hA5A5_0F0F);
        m0_valid = 1'b0; s_ready = 1'b0;
        step();
        chk("t6_err_clear", o_err, 1'b0);
`endif

        // Random traffic: masters hold requests until served, random slave.
        wt[0] = 0; wt[1] = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (m0_valid && o_r0) begin
                n_checks++;
                if (wt[0] > 400) begin n_fail++; $display("FAIL m0_wait_bound: got %0d required <=400", wt[0]); end
                m0_valid = 1'b0; wt[0] = 0;
            end
            if (m1_valid && o_r1) begin
                n_checks++;
                if (wt[1] > 400) begin n_fail++; $display("FAIL m1_wait_bound: got %0d required <=400", wt[1]); end
                m1_valid = 1'b0; wt[1] = 0;
            end
            if (!m0_valid && ($urandom % 3 == 0)) begin
                m0_valid = 1'b1; m0_instr = 1'($urandom); m0_addr = $urandom;
                m0_wdata = $urandom; m0_wstrb = 4'($urandom);
            end
            if (!m1_valid && ($urandom % 3 == 0)) begin
                m1_valid = 1'b1; m1_instr = 1'($urandom); m1_addr = $urandom;
                m1_wdata = $urandom; m1_wstrb = 4'($urandom);
            end
            lat = $urandom % 3;
            s_ready = (lat == 0);
            s_rdata = $urandom;
            reset = ($urandom % 300 == 0);
            if (m0_valid) wt[0]++;
            if (m1_valid) wt[1]++;
            if (wt[0] > 400 || wt[1] > 400) begin
                n_checks++; n_fail++;
                $display("FAIL starvation: wait %0d/%0d required <=400", wt[0], wt[1]);
                wt[0] = 0; wt[1] = 0;
            end
            step();
        end
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
